// File: rtl/prime_arbiter.sv
// rtl/prime_arbiter.sv - round-robin arbiter sharing one prime generator among NREQ requesters; optional wait timeout via PRIME_ARBITER_TIMEOUT_EN
module prime_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] resp_valid,
    output logic [15:0]     resp_data,
    output logic            resp_err,
    output logic            busy,
    output logic            gen_go,
    input  logic            gen_ready,
    input  logic            gen_error,
    input  logic [15:0]     gen_res
);

    localparam int OW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last_owner;
    logic [OW-1:0]   pick;
    logic [OW-1:0]   pick_hi;
    logic [OW-1:0]   pick_lo;
    logic            hi_valid;
    logic            lo_valid;
    logic            in_wait;
    logic            timeout;

    assign in_wait = (state == WAIT_LOW) || (state == WAIT_HIGH);

`ifdef PRIME_ARBITER_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Wait watchdog: restarts when the generator is kicked, counts every wait cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 8'd0;
        end else if (state == ISSUE) begin
            wait_cnt <= 8'd0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout = in_wait && (wait_cnt == 8'hFF);
`else
    assign timeout = 1'b0;
`endif

    // Round-robin pick: lowest set bit above last_owner, otherwise lowest set bit overall
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        hi_valid = 1'b0;
        lo_valid = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                if (j > int'(last_owner)) begin
                    pick_hi  = OW'(j);
                    hi_valid = 1'b1;
                end else begin
                    pick_lo  = OW'(j);
                    lo_valid = 1'b1;
                end
            end
        end
        pick = hi_valid ? pick_hi : pick_lo;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a real generator result in WAIT_HIGH beats a coincident timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if ((hi_valid || lo_valid) && gen_ready) state_next = ISSUE;
            ISSUE:     state_next = WAIT_LOW;
            WAIT_LOW:  if (!gen_ready) state_next = WAIT_HIGH;
                       else if (timeout) state_next = DONE;
            WAIT_HIGH: if (gen_ready || timeout) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs decoded from state so reset clears them in the same cycle
    always_comb begin
        gen_go     = (state == ISSUE);
        busy       = (state != IDLE);
        resp_valid = '0;
        if (state == DONE) begin
            resp_valid[owner] = 1'b1;
        end
    end

    // Owner bookkeeping and result capture; results hold until the next completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= '0;
            last_owner <= OW'(NREQ - 1);
            resp_data  <= 16'd0;
            resp_err   <= 1'b0;
        end else begin
            if (state == IDLE && state_next == ISSUE) begin
                owner <= pick;
            end
            if (state == DONE) begin
                last_owner <= owner;
            end
            if (state == WAIT_HIGH && gen_ready) begin
                resp_data <= gen_res;
                resp_err  <= gen_error;
            end else if (timeout) begin
                resp_data <= 16'd0;
                resp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prime_arbiter.sv
// tb/tb_prime_arbiter.sv - scoreboard bench for prime_arbiter with a behavioural prime generator
module tb_prime_arbiter;

    localparam int NREQ    = 4;
    localparam int COMPUTE = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] resp_valid;
    logic [15:0]     resp_data;
    logic            resp_err;
    logic            busy;
    logic            gen_go;
    logic            gen_ready;
    logic            gen_error;
    logic [15:0]     gen_res;

    prime_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy),
        .gen_go     (gen_go),
        .gen_ready  (gen_ready),
        .gen_error  (gen_error),
        .gen_res    (gen_res)
    );

    always #5 clk = ~clk;

    logic [15:0] primes [0:15] = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd17, 16'd19,
                                   16'd23, 16'd29, 16'd31, 16'd37, 16'd41, 16'd43, 16'd47, 16'd53};
    int gen_cnt;
    int prime_idx;
    bit hang       = 1'b0;
    bit err_inject = 1'b0;

    // Generator model: drops ready on gen_go, returns the next prime COMPUTE cycles later
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_ready <= 1'b1;
            gen_error <= 1'b0;
            gen_res   <= 16'd0;
            gen_cnt   <= 0;
            prime_idx <= 0;
        end else if (gen_go) begin
            gen_ready <= 1'b0;
            gen_cnt   <= hang ? 0 : COMPUTE;
        end else if (gen_cnt > 1) begin
            gen_cnt <= gen_cnt - 1;
        end else if (gen_cnt == 1) begin
            gen_ready <= 1'b1;
            gen_res   <= primes[prime_idx];
            gen_error <= err_inject;
            prime_idx <= prime_idx + 1;
            gen_cnt   <= 0;
        end
    end

    typedef struct packed {
        logic [NREQ-1:0] vld;
        logic [15:0]     data;
        logic            err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   go_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] vld, input logic [15:0] data, input logic err);
        exp_t x;
        x.vld  = vld;
        x.data = data;
        x.err  = err;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (gen_go) go_cnt++;
    end

    // Monitor: every completion pulse is matched against the head of the scoreboard
    always @(negedge clk) begin
        if (resp_valid !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_resp_valid", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_valid", 32'(resp_valid), 32'(e.vld));
                check("resp_data", 32'(resp_data), 32'(e.data));
                check("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    // Raise req and drop each bit once its own completion pulse appears
    task automatic serve(input logic [NREQ-1:0] r, input int max_cyc, output int lat);
        logic [NREQ-1:0] pending;
        pending = r;
        req     = r;
        lat     = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if ((resp_valid & pending) != '0) begin
                req     = req & ~resp_valid;
                pending = pending & ~resp_valid;
            end
            if (pending == '0) begin
                lat = c;
                break;
            end
        end
        check("serve_all_granted", 32'(pending), 32'd0);
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_to_idle", 32'(ok), 32'd1);
    endtask

    task automatic wait_go(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (gen_go) begin
                seen = 1'b1;
                break;
            end
        end
        check("gen_go_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        bit ok;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gen_go", 32'(gen_go), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single requester, first prime, exact latency with a 3-cycle generator
        push(4'b0001, 16'd2, 1'b0);
        base = go_cnt;
        serve(4'b0001, 40, lat);
        check("latency_single", 32'(lat), 32'd6);
        wait_idle(20);
        check("gen_go_once_single", 32'(go_cnt - base), 32'd1);

        // Fresh reset: all four requesting are served 0,1,2,3
        rst = 1'b0;
        @(negedge clk);
        check("rst_clears_data", 32'(resp_data), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        push(4'b0001, 16'd2, 1'b0);
        push(4'b0010, 16'd3, 1'b0);
        push(4'b0100, 16'd5, 1'b0);
        push(4'b1000, 16'd7, 1'b0);
        serve(4'b1111, 200, lat);
        wait_idle(20);

        // Requester 1 served, then 1011 together goes 3,0,1
        push(4'b0010, 16'd11, 1'b0);
        serve(4'b0010, 40, lat);
        push(4'b1000, 16'd13, 1'b0);
        push(4'b0001, 16'd17, 1'b0);
        push(4'b0010, 16'd19, 1'b0);
        serve(4'b1011, 200, lat);
        wait_idle(20);

        // Requester 2 withdraws after grant; result and error flag still delivered
        err_inject = 1'b1;
        push(4'b0100, 16'd23, 1'b1);
        base = go_cnt;
        req  = 4'b0100;
        wait_go(20);
        @(negedge clk);
        req = 4'b0000;
        wait_idle(40);
        check("gen_go_once_drop", 32'(go_cnt - base), 32'd1);
        err_inject = 1'b0;

        // Reset during WAIT_HIGH aborts with no completion
        req = 4'b0001;
        wait_go(20);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_gen_go", 32'(gen_go), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_resp_data", 32'(resp_data), 32'd0);
        check("abort_resp_err", 32'(resp_err), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push(4'b0001, 16'd2, 1'b0);
        serve(4'b0001, 40, lat);
        wait_idle(20);

        // Generator never comes back
        hang = 1'b1;
`ifdef PRIME_ARBITER_TIMEOUT_EN
        push(4'b0010, 16'd0, 1'b1);
        serve(4'b0010, 400, lat);
        wait_idle(20);
`else
        req = 4'b0010;
        wait_go(20);
        req = 4'b0000;
        ok  = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (!busy || resp_valid != '0) ok = 1'b0;
        end
        check("hang_busy_held", 32'(ok), 32'd1);
`endif
        hang = 1'b0;
        rst  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
